// File: rtl/rom_access_arbiter_pkg.sv
// Purpose : shared widths and owner encoding for the Hack instruction-ROM arbiter.
// Latency : n/a (definitions only).
// Backpr. : n/a.
package rom_access_arbiter_pkg;

  localparam int HACK_ADDR_W = 15;
  localparam int HACK_DATA_W = 16;

  // Which requester's read is in flight in the ROM this cycle.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_DBG  = 2'd2
  } owner_e;

endpackage : rom_access_arbiter_pkg

// File: rtl/rom_access_arbiter_if.sv
// Purpose : bundles the CPU fetch port, debug port, ROM port and conflict counter.
// Latency : n/a (wires only).
// Backpr. : req held until gnt; rvalid always one cycle after gnt, no stall.
// Ports   : master = requesters + ROM model side, slave = arbiter side.
interface rom_access_arbiter_if
  import rom_access_arbiter_pkg::*;
#(
  parameter int ADDR_W = HACK_ADDR_W,
  parameter int DATA_W = HACK_DATA_W,
  parameter int CNT_W  = 16
);
  logic              cpu_req;
  logic [ADDR_W-1:0] cpu_addr;
  logic              cpu_gnt;
  logic              cpu_rvalid;
  logic [DATA_W-1:0] cpu_rdata;
  logic              dbg_req;
  logic [ADDR_W-1:0] dbg_addr;
  logic              dbg_gnt;
  logic              dbg_rvalid;
  logic [DATA_W-1:0] dbg_rdata;
  logic [ADDR_W-1:0] rom_address;
  logic [DATA_W-1:0] rom_data;
  logic [CNT_W-1:0]  conflict_count;

  modport master (
    output cpu_req, cpu_addr, dbg_req, dbg_addr, rom_data,
    input  cpu_gnt, cpu_rvalid, cpu_rdata, dbg_gnt, dbg_rvalid, dbg_rdata,
    input  rom_address, conflict_count
  );

  modport slave (
    input  cpu_req, cpu_addr, dbg_req, dbg_addr, rom_data,
    output cpu_gnt, cpu_rvalid, cpu_rdata, dbg_gnt, dbg_rvalid, dbg_rdata,
    output rom_address, conflict_count
  );
endinterface : rom_access_arbiter_if

// File: rtl/rom_burst_limiter.sv
// Purpose : counts back-to-back CPU grants won against a waiting debug request.
// Latency : force_dbg_o is registered state, valid the cycle after the count reaches the limit.
// Backpr. : none; forces one debug grant once MAX_CPU_BURST CPU grants were taken.
// Ports   : clk/reset, dbg_req_i, cpu_gnt_i, dbg_gnt_i in; force_dbg_o out.
module rom_burst_limiter #(
  parameter int MAX_CPU_BURST = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic dbg_req_i,
  input  logic cpu_gnt_i,
  input  logic dbg_gnt_i,
  output logic force_dbg_o
);
  localparam int BW = $clog2(MAX_CPU_BURST + 1);

  logic [BW-1:0] burst_cnt_q, burst_cnt_d;

  always_comb begin
    burst_cnt_d = burst_cnt_q;
    // The count only matters while debug is actually waiting.
    if (!dbg_req_i || dbg_gnt_i) begin
      burst_cnt_d = '0;
    end else if (cpu_gnt_i && (burst_cnt_q != BW'(MAX_CPU_BURST))) begin
      burst_cnt_d = burst_cnt_q + BW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) burst_cnt_q <= '0;
    else       burst_cnt_q <= burst_cnt_d;
  end

  assign force_dbg_o = (burst_cnt_q == BW'(MAX_CPU_BURST));

endmodule : rom_burst_limiter

// File: rtl/rom_access_arbiter.sv
// Purpose : shares the 1-cycle single-port instruction ROM between CPU fetch and debug reader.
// Latency : gnt combinational with req; rvalid/rdata exactly one cycle after gnt.
// Backpr. : CPU has fixed priority; debug wins after MAX_CPU_BURST contested CPU grants.
// Ports   : clk, reset (async, active-high), bus_if (slave side of rom_access_arbiter_if).
module rom_access_arbiter
  import rom_access_arbiter_pkg::*;
#(
  parameter int ADDR_W        = HACK_ADDR_W,
  parameter int DATA_W        = HACK_DATA_W,
  parameter int MAX_CPU_BURST = 4,
  parameter int CNT_W         = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  rom_access_arbiter_if.slave  bus_if
);
  owner_e            owner_q, owner_d;
  logic [ADDR_W-1:0] last_addr_q;
  logic [CNT_W-1:0]  conflict_q, conflict_d;
  logic [DATA_W-1:0] cpu_hold_q, dbg_hold_q;
  logic              cpu_gnt, dbg_gnt, force_dbg, conflict;
  logic [ADDR_W-1:0] rom_addr;

  assign conflict = bus_if.cpu_req && bus_if.dbg_req;

  rom_burst_limiter #(.MAX_CPU_BURST(MAX_CPU_BURST)) u_burst (
    .clk         (clk),
    .reset       (reset),
    .dbg_req_i   (bus_if.dbg_req),
    .cpu_gnt_i   (cpu_gnt),
    .dbg_gnt_i   (dbg_gnt),
    .force_dbg_o (force_dbg)
  );

  // Grant mux and next owner. Grants are suppressed while reset is held so the
  // ROM address sits at zero and nothing is launched that reset would orphan.
  always_comb begin
    cpu_gnt  = 1'b0;
    dbg_gnt  = 1'b0;
    owner_d  = OWN_NONE;
    rom_addr = last_addr_q;
    if (!reset) begin
      if (bus_if.cpu_req && !(bus_if.dbg_req && force_dbg)) begin
        cpu_gnt = 1'b1;
      end else if (bus_if.dbg_req) begin
        dbg_gnt = 1'b1;
      end
    end
    if (cpu_gnt) begin
      owner_d  = OWN_CPU;
      rom_addr = bus_if.cpu_addr;
    end else if (dbg_gnt) begin
      owner_d  = OWN_DBG;
      rom_addr = bus_if.dbg_addr;
    end
  end

  // Saturating conflict counter: stop at all-ones.
  always_comb begin
    conflict_d = conflict_q;
    if (conflict && (conflict_q != {CNT_W{1'b1}})) conflict_d = conflict_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner_q     <= OWN_NONE;
      last_addr_q <= '0;
      conflict_q  <= '0;
      cpu_hold_q  <= '0;
      dbg_hold_q  <= '0;
    end else begin
      owner_q     <= owner_d;
      last_addr_q <= rom_addr;
      conflict_q  <= conflict_d;
      if (owner_q == OWN_CPU) cpu_hold_q <= bus_if.rom_data;
      if (owner_q == OWN_DBG) dbg_hold_q <= bus_if.rom_data;
    end
  end

  // Owner of the previous cycle's address receives this cycle's ROM word;
  // the other side keeps presenting the last word it was given.
  assign bus_if.cpu_gnt        = cpu_gnt;
  assign bus_if.dbg_gnt        = dbg_gnt;
  assign bus_if.rom_address    = rom_addr;
  assign bus_if.cpu_rvalid     = (owner_q == OWN_CPU);
  assign bus_if.dbg_rvalid     = (owner_q == OWN_DBG);
  assign bus_if.cpu_rdata      = (owner_q == OWN_CPU) ? bus_if.rom_data : cpu_hold_q;
  assign bus_if.dbg_rdata      = (owner_q == OWN_DBG) ? bus_if.rom_data : dbg_hold_q;
  assign bus_if.conflict_count = conflict_q;

endmodule : rom_access_arbiter

// File: tb/tb_rom_access_arbiter.sv
module tb_rom_access_arbiter;
  import rom_access_arbiter_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  rom_access_arbiter_if #(.ADDR_W(15), .DATA_W(16), .CNT_W(16)) bus0 ();
  rom_access_arbiter_if #(.ADDR_W(15), .DATA_W(16), .CNT_W(4))  bus1 ();

  rom_access_arbiter #(.ADDR_W(15), .DATA_W(16), .MAX_CPU_BURST(4), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .bus_if(bus0.slave));
  rom_access_arbiter #(.ADDR_W(15), .DATA_W(16), .MAX_CPU_BURST(4), .CNT_W(4)) dut_sat (
    .clk(clk), .reset(reset), .bus_if(bus1.slave));

  // ROM model: registered output, one cycle after the address is sampled.
  logic [15:0] rom_mem [0:63];
  always @(posedge clk) begin
    bus0.rom_data <= rom_mem[bus0.rom_address[5:0]];
    bus1.rom_data <= rom_mem[bus1.rom_address[5:0]];
  end

  typedef struct {
    logic        creq;
    logic [14:0] caddr;
    logic        dreq;
    logic [14:0] daddr;
    logic        ecg;
    logic        edg;
    logic [14:0] erom;
  } vec_t;

  typedef struct {
    owner_e      who;
    logic [15:0] data;
  } sb_t;

  vec_t        vecs[$];
  sb_t         sb[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [15:0] last_cpu = '0;
  logic [15:0] last_dbg = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Called at a negedge: compares what the DUT delivers against the scoreboard.
  task automatic check_resp(input string tag);
    sb_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.who == OWN_CPU) begin
        chk({tag, " cpu_rvalid"}, 32'(bus0.cpu_rvalid), 32'd1);
        chk({tag, " cpu_rdata"},  32'(bus0.cpu_rdata),  32'(e.data));
        chk({tag, " dbg_rvalid"}, 32'(bus0.dbg_rvalid), 32'd0);
        chk({tag, " dbg_hold"},   32'(bus0.dbg_rdata),  32'(last_dbg));
        last_cpu = e.data;
      end else begin
        chk({tag, " dbg_rvalid"}, 32'(bus0.dbg_rvalid), 32'd1);
        chk({tag, " dbg_rdata"},  32'(bus0.dbg_rdata),  32'(e.data));
        chk({tag, " cpu_rvalid"}, 32'(bus0.cpu_rvalid), 32'd0);
        chk({tag, " cpu_hold"},   32'(bus0.cpu_rdata),  32'(last_cpu));
        last_dbg = e.data;
      end
    end else begin
      chk({tag, " idle cpu_rvalid"}, 32'(bus0.cpu_rvalid), 32'd0);
      chk({tag, " idle dbg_rvalid"}, 32'(bus0.dbg_rvalid), 32'd0);
    end
  endtask

  // One clock cycle on dut: check responses, drive, check grants, advance.
  task automatic apply(input vec_t v, input string tag);
    check_resp(tag);
    bus0.cpu_req  = v.creq;
    bus0.cpu_addr = v.caddr;
    bus0.dbg_req  = v.dreq;
    bus0.dbg_addr = v.daddr;
    #1;
    chk({tag, " cpu_gnt"},     32'(bus0.cpu_gnt),     32'(v.ecg));
    chk({tag, " dbg_gnt"},     32'(bus0.dbg_gnt),     32'(v.edg));
    chk({tag, " rom_address"}, 32'(bus0.rom_address), 32'(v.erom));
    if (v.ecg) sb.push_back('{OWN_CPU, rom_mem[v.caddr[5:0]]});
    if (v.edg) sb.push_back('{OWN_DBG, rom_mem[v.daddr[5:0]]});
    @(negedge clk);
  endtask

  function automatic vec_t mk(input logic cr, input int ca, input logic dr, input int da,
                              input logic ecg, input logic edg, input int erom);
    vec_t v;
    v.creq = cr;  v.caddr = 15'(ca);
    v.dreq = dr;  v.daddr = 15'(da);
    v.ecg  = ecg; v.edg   = edg;   v.erom = 15'(erom);
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    int ncpu, ndbg;
    for (int k = 0; k < 64; k++) rom_mem[k] = 16'h1000 + 16'(k * 3);
    rom_mem[0] = 16'h0005; rom_mem[1] = 16'hEC10;
    rom_mem[2] = 16'h0005; rom_mem[3] = 16'h0005;
    rom_mem[4] = 16'h0005; rom_mem[5] = 16'h0005;
    rom_mem[6] = 16'hEC07;

    bus0.cpu_req = 0; bus0.cpu_addr = '0; bus0.dbg_req = 0; bus0.dbg_addr = '0;
    bus1.cpu_req = 0; bus1.cpu_addr = '0; bus1.dbg_req = 0; bus1.dbg_addr = '0;
    reset = 1'b1;
    #1;
    chk("reset cpu_rvalid",  32'(bus0.cpu_rvalid),     32'd0);
    chk("reset dbg_rvalid",  32'(bus0.dbg_rvalid),     32'd0);
    chk("reset rom_address", 32'(bus0.rom_address),    32'd0);
    chk("reset conflict",    32'(bus0.conflict_count), 32'd0);
    @(negedge clk); @(negedge clk);
    reset = 1'b0;

    // CPU-only fetch of 0..6, then a debug-only read of address 6.
    for (int i = 0; i <= 6; i++) vecs.push_back(mk(1, i, 0, 0, 1, 0, i));
    vecs.push_back(mk(0, 0, 1, 6, 0, 1, 6));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 6));
    foreach (vecs[i]) apply(vecs[i], $sformatf("fetch[%0d]", i));

    // One contested cycle, then reset while that CPU read is in flight.
    apply(mk(1, 2, 1, 9, 1, 0, 2), "contest");
    chk("pre-reset conflict", 32'(bus0.conflict_count), 32'd1);
    bus0.cpu_req = 0; bus0.dbg_req = 0;
    reset = 1'b1;
    #1;
    chk("midrun cpu_rvalid",  32'(bus0.cpu_rvalid),     32'd0);
    chk("midrun dbg_rvalid",  32'(bus0.dbg_rvalid),     32'd0);
    chk("midrun rom_address", 32'(bus0.rom_address),    32'd0);
    chk("midrun conflict",    32'(bus0.conflict_count), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    sb.delete(); last_cpu = '0; last_dbg = '0;

    // Both requesting for 20 cycles: C,C,C,C,D repeating.
    vecs.delete();
    for (int i = 0; i < 20; i++) begin
      if (i % 5 == 4) vecs.push_back(mk(1, i % 7, 1, 20 + i / 5, 0, 1, 20 + i / 5));
      else            vecs.push_back(mk(1, i % 7, 1, 20 + i / 5, 1, 0, i % 7));
    end
    // No requests: ROM address holds the last granted address (debug 23).
    for (int i = 0; i < 3; i++) vecs.push_back(mk(0, 5, 0, 0, 0, 0, 23));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 23));
    ncpu = 0; ndbg = 0;
    foreach (vecs[i]) begin
      apply(vecs[i], $sformatf("burst[%0d]", i));
      if (i < 20) begin
        ncpu += (vecs[i].ecg ? 1 : 0);
        ndbg += (vecs[i].edg ? 1 : 0);
      end
      if (i == 19) chk("burst conflict", 32'(bus0.conflict_count), 32'd20);
    end
    chk("burst conflict after idle", 32'(bus0.conflict_count), 32'd20);
    if (ncpu != 16 || ndbg != 4) begin
      n_fail++;
      $display("FAIL burst table: %0d C / %0d D, expected 16 / 4", ncpu, ndbg);
    end

    // Debug grant, then reset pulsed while its word is in flight.
    bus0.dbg_req = 1; bus0.dbg_addr = 15'd3;
    #1;
    chk("rst-dbg gnt", 32'(bus0.dbg_gnt), 32'd1);
    @(posedge clk);
    #1;
    bus0.dbg_req = 0;
    reset = 1'b1;
    #1;
    chk("rst-dbg rvalid in reset", 32'(bus0.dbg_rvalid), 32'd0);
    reset = 1'b0;
    #1;
    chk("rst-dbg rvalid after",    32'(bus0.dbg_rvalid), 32'd0);
    sb.delete(); last_cpu = '0; last_dbg = '0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) apply(mk(0, 0, 0, 0, 0, 0, 0), $sformatf("rst-dbg idle[%0d]", i));
    check_resp("rst-dbg final");

    // 4-bit conflict counter saturates at 15.
    bus1.cpu_req = 1; bus1.dbg_req = 1; bus1.cpu_addr = 15'd1; bus1.dbg_addr = 15'd2;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i == 14) chk("sat count 14", 32'(bus1.conflict_count), 32'd14);
      if (i == 15) chk("sat count 15", 32'(bus1.conflict_count), 32'd15);
      if (i == 16) chk("sat count 16", 32'(bus1.conflict_count), 32'd15);
    end
    chk("sat count 20", 32'(bus1.conflict_count), 32'd15);
    bus1.cpu_req = 0; bus1.dbg_req = 0;
    @(negedge clk);
    chk("sat count idle", 32'(bus1.conflict_count), 32'd15);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_rom_access_arbiter
